warp_scheduler: RTL and testbench

WARP_SCHEDULER -- requirements
Module: warp_scheduler

---
 rtl/warp_scheduler.sv | 149 ++++++++++++++
 tb/tb_warp_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_scheduler.sv
// Multi-warp instruction scheduler: time-multiplexes one ALU/LSU datapath across
// NUM_WARPS warps, each with its own PC, using round-robin selection per instruction.
module warp_scheduler #(
   parameter int NUM_WARPS = 4,
   parameter int PC_W      = 8,
   localparam int AW       = $clog2(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_WARPS-1:0] warp_mask,
   output logic                 fetch_req,
   output logic [PC_W-1:0]      fetch_addr,
   input  logic                 fetch_ready,
   input  logic                 decoded_mem,
   input  logic                 decoded_ret,
   output logic                 lsu_req,
   input  logic                 lsu_done,
   output logic [2:0]           warp_state,
   output logic [AW-1:0]        active_warp,
   output logic [PC_W-1:0]      pc,
   input  logic                 pc_jump,
   input  logic [31:0]          alu_out,
   output logic                 done
);

   typedef enum logic [2:0] {
      WARP_IDLE    = 3'd0,
      WARP_FETCH   = 3'd1,
      WARP_DECODE  = 3'd2,
      WARP_REQUEST = 3'd3,
      WARP_WAIT    = 3'd4,
      WARP_EXECUTE = 3'd5,
      WARP_UPDATE  = 3'd6,
      WARP_DONE    = 3'd7
   } warp_state_t;

   warp_state_t          state_q, state_d;
   logic [NUM_WARPS-1:0] live_q, live_d;
   logic [PC_W-1:0]      pc_q [NUM_WARPS];
   logic [PC_W-1:0]      pc_d [NUM_WARPS];
   logic [AW-1:0]        active_q, active_d;
   logic                 mem_pend_q, mem_pend_d;
   logic                 ret_q, ret_d;

   logic [AW-1:0]        first_warp;
   logic [AW-1:0]        next_warp;
   logic [AW-1:0]        cand;
   logic                 found;

   // Lowest enabled warp in the launch mask.
   always_comb begin
      first_warp = '0;
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
         if (warp_mask[i]) first_warp = AW'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      live_d     = live_q;
      pc_d       = pc_q;
      active_d   = active_q;
      mem_pend_d = mem_pend_q;
      ret_d      = ret_q;
      next_warp  = active_q;
      cand       = active_q;
      found      = 1'b0;

      case (state_q)
         WARP_IDLE, WARP_DONE: begin
            if (start) begin
               live_d   = warp_mask;
               active_d = first_warp;
               for (int i = 0; i < NUM_WARPS; i++) pc_d[i] = '0;
               state_d  = (warp_mask == '0) ? WARP_DONE : WARP_FETCH;
            end
         end
         WARP_FETCH: begin
            if (fetch_ready) state_d = WARP_DECODE;
         end
         WARP_DECODE: begin
            mem_pend_d = decoded_mem;
            ret_d      = decoded_ret;
            state_d    = WARP_REQUEST;
         end
         WARP_REQUEST: state_d = WARP_WAIT;
         WARP_WAIT: begin
            if (!mem_pend_q || lsu_done) state_d = WARP_EXECUTE;
         end
         WARP_EXECUTE: state_d = WARP_UPDATE;
         WARP_UPDATE: begin
            if (ret_q) begin
               live_d[active_q] = 1'b0;
            end else begin
               pc_d[active_q] = pc_jump ? alu_out[PC_W-1:0] : pc_q[active_q] + PC_W'(1);
            end
            // Search starts after the current warp and wraps back onto it last.
            for (int i = 1; i <= NUM_WARPS; i++) begin
               cand = active_q + AW'(i);
               if (!found && live_d[cand]) begin
                  found     = 1'b1;
                  next_warp = cand;
               end
            end
            if (found) begin
               active_d = next_warp;
               state_d  = WARP_FETCH;
            end else begin
               state_d  = WARP_DONE;
            end
         end
         default: state_d = WARP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WARP_IDLE;
         live_q     <= '0;
         active_q   <= '0;
         mem_pend_q <= 1'b0;
         ret_q      <= 1'b0;
         for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         live_q     <= live_d;
         active_q   <= active_d;
         mem_pend_q <= mem_pend_d;
         ret_q      <= ret_d;
         pc_q       <= pc_d;
      end
   end

   assign fetch_req   = (state_q == WARP_FETCH);
   assign lsu_req     = (state_q == WARP_REQUEST) && mem_pend_q;
   assign done        = (state_q == WARP_DONE);
   assign warp_state  = state_q;
   assign active_warp = active_q;
   assign pc          = pc_q[active_q];
   assign fetch_addr  = pc_q[active_q];

   // Only the low PC_W bits of the ALU result form a jump target.
   if (PC_W < 32) begin : g_alu_hi
      logic unused_alu_hi;
      assign unused_alu_hi = ^alu_out[31:PC_W];
   end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed and randomized bench for warp_scheduler, checked against a per-instruction
// model of warp PCs, the live set and round-robin ownership.
module tb_warp_scheduler;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_REQUEST = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_EXECUTE = 3'd5;
   localparam logic [2:0] S_UPDATE  = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic        clk = 1'b0;
   logic        reset, start, fetch_ready, decoded_mem, decoded_ret, lsu_done, pc_jump;
   logic [3:0]  warp_mask;
   logic [31:0] alu_out;
   logic        fetch_req, lsu_req, done;
   logic [7:0]  fetch_addr, pc;
   logic [2:0]  warp_state;
   logic [1:0]  active_warp;

   int vectors = 0;
   int miscompares = 0;

   bit [3:0]  m_live;
   logic [7:0] m_pc [4];
   int        m_act;

   warp_scheduler #(.NUM_WARPS(4), .PC_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .warp_mask(warp_mask),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .decoded_mem(decoded_mem), .decoded_ret(decoded_ret), .lsu_req(lsu_req),
      .lsu_done(lsu_done), .warp_state(warp_state), .active_warp(active_warp),
      .pc(pc), .pc_jump(pc_jump), .alu_out(alu_out), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_state"}, 32'(warp_state), 32'(S_IDLE));
      chk({tag, "_fetch_req"}, 32'(fetch_req), 32'd0);
      chk({tag, "_lsu_req"}, 32'(lsu_req), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pc"}, 32'(pc), 32'd0);
   endtask

   task automatic model_reset();
      m_live = '0;
      m_act  = 0;
      for (int i = 0; i < 4; i++) m_pc[i] = 8'd0;
   endtask

   task automatic launch(input logic [3:0] mask);
      start = 1'b1;
      warp_mask = mask;
      step();
      start = 1'b0;
      warp_mask = 4'($urandom);
      m_live = mask;
      for (int i = 0; i < 4; i++) m_pc[i] = 8'd0;
      m_act = 0;
      for (int i = 3; i >= 0; i--) if (mask[i]) m_act = i;
      if (mask == 4'd0) begin
         chk("launch_empty_state", 32'(warp_state), 32'(S_DONE));
         chk("launch_empty_done", 32'(done), 32'd1);
         chk("launch_empty_fetch", 32'(fetch_req), 32'd0);
      end else begin
         chk("launch_state", 32'(warp_state), 32'(S_FETCH));
      end
   endtask

   task automatic run_instr(input bit mem, input bit ret, input bit jmp,
                            input logic [31:0] tgt, input int fw, input int lw);
      int  nxt;
      bit  found;
      nxt = m_act;
      found = 1'b0;
      chk("fetch_state", 32'(warp_state), 32'(S_FETCH));
      chk("fetch_req", 32'(fetch_req), 32'd1);
      chk("fetch_addr", 32'(fetch_addr), 32'(m_pc[m_act]));
      chk("active_warp", 32'(active_warp), 32'(m_act));
      repeat (fw) begin
         fetch_ready = 1'b0;
         lsu_done = 1'($urandom);
         step();
         chk("fetch_hold", 32'(warp_state), 32'(S_FETCH));
      end
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      lsu_done = 1'($urandom);
      chk("decode_state", 32'(warp_state), 32'(S_DECODE));
      decoded_mem = mem;
      decoded_ret = ret;
      step();
      decoded_mem = 1'($urandom);
      decoded_ret = 1'($urandom);
      chk("request_state", 32'(warp_state), 32'(S_REQUEST));
      chk("request_lsu_req", 32'(lsu_req), 32'(mem));
      lsu_done = 1'b0;
      step();
      chk("wait_state", 32'(warp_state), 32'(S_WAIT));
      chk("wait_lsu_req", 32'(lsu_req), 32'd0);
      if (mem) begin
         repeat (lw) begin
            step();
            chk("wait_hold", 32'(warp_state), 32'(S_WAIT));
            chk("wait_hold_lsu_req", 32'(lsu_req), 32'd0);
         end
         lsu_done = 1'b1;
         step();
         lsu_done = 1'b0;
      end else begin
         step();
      end
      chk("execute_state", 32'(warp_state), 32'(S_EXECUTE));
      lsu_done = 1'($urandom);
      step();
      chk("update_state", 32'(warp_state), 32'(S_UPDATE));
      pc_jump = jmp;
      alu_out = tgt;
      step();
      pc_jump = 1'($urandom);
      alu_out = $urandom;
      lsu_done = 1'b0;

      if (ret) m_live[m_act] = 1'b0;
      else     m_pc[m_act] = jmp ? tgt[7:0] : m_pc[m_act] + 8'd1;
      for (int k = 1; k <= 4; k++) begin
         if (!found && m_live[(m_act + k) % 4]) begin
            found = 1'b1;
            nxt = (m_act + k) % 4;
         end
      end
      if (found) begin
         m_act = nxt;
         chk("next_state_fetch", 32'(warp_state), 32'(S_FETCH));
      end else begin
         chk("next_state_done", 32'(warp_state), 32'(S_DONE));
         chk("done_out", 32'(done), 32'd1);
      end
      chk("next_active", 32'(active_warp), 32'(m_act));
      chk("next_pc", 32'(pc), 32'(m_pc[m_act]));
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b1; warp_mask = 4'hF; fetch_ready = 1'b1;
      decoded_mem = 1'b0; decoded_ret = 1'b0; lsu_done = 1'b1; pc_jump = 1'b0;
      alu_out = 32'd0;
      model_reset();
      step();
      chk_quiet("in_reset_a");
      step();
      chk_quiet("in_reset_b");
      start = 1'b0;
      reset = 1'b0;
      step();
      chk_quiet("post_reset");
      fetch_ready = 1'b0; lsu_done = 1'b0;

      // Empty mask goes straight to DONE.
      launch(4'b0000);

      // Two interleaved warps; a start during FETCH must be ignored.
      launch(4'b0101);
      run_instr(0, 0, 0, 32'd0, 0, 0);
      run_instr(0, 0, 0, 32'd0, 0, 0);
      start = 1'b1; warp_mask = 4'b1111; fetch_ready = 1'b0;
      step();
      start = 1'b0;
      chk("start_in_fetch_state", 32'(warp_state), 32'(S_FETCH));
      chk("start_in_fetch_addr", 32'(fetch_addr), 32'(m_pc[m_act]));
      for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 32'd0, 0, 0);
      run_instr(0, 1, 0, 32'd0, 0, 0);
      run_instr(0, 1, 0, 32'd0, 0, 0);

      // Jump target, PC wrap at 8'hFF.
      launch(4'b0001);
      run_instr(0, 0, 1, 32'h0000_0010, 0, 0);
      run_instr(0, 0, 1, 32'hABCD_00FF, 1, 0);
      run_instr(0, 0, 0, 32'hFFFF_FFFF, 0, 0);
      run_instr(0, 1, 0, 32'd0, 0, 0);

      // Long LSU wait.
      launch(4'b0001);
      run_instr(1, 0, 0, 32'd0, 0, 6);
      run_instr(1, 1, 0, 32'd0, 2, 0);

      // All four warps retire on their first instruction, in order.
      launch(4'b1111);
      for (int i = 0; i < 4; i++) run_instr(0, 1, 0, 32'd0, 0, 0);

      // Randomized kernels.
      for (int kk = 0; kk < 6; kk++) begin
         launch(4'($urandom_range(1, 15)));
         n = 0;
         while (m_live != 4'd0 && n < 120) begin
            run_instr(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                      $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
            n++;
         end
         chk("random_kernel_done", 32'(done), 32'd1);
      end

      // Reset while waiting on the LSU abandons the kernel.
      launch(4'b0011);
      run_instr(0, 0, 1, 32'h0000_0033, 0, 0);
      run_instr(0, 0, 1, 32'h0000_0044, 0, 0);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      decoded_mem = 1'b1;
      step();
      step();
      chk("pre_reset_wait", 32'(warp_state), 32'(S_WAIT));
      chk("pre_reset_pc", 32'(pc), 32'h33);
      reset = 1'b1; lsu_done = 1'b1; fetch_ready = 1'b1;
      step();
      model_reset();
      chk_quiet("reset_in_wait");
      chk("reset_in_wait_active", 32'(active_warp), 32'd0);
      reset = 1'b0;
      step();
      chk_quiet("after_reset_in_wait");
      lsu_done = 1'b0; fetch_ready = 1'b0;
      launch(4'b0010);
      run_instr(0, 1, 0, 32'd0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
